mem_arbiter_rr: RTL and testbench

Parametrised N-channel arbiter that shares one physical-memory port among N_CH cache clients (I-cache, D-cache, prefetcher, …). Supports both reads and writes, registers a single owner per transaction, muxes address/write data from the owner to memory and routes the response back to that owner only. Sits between the L1 caches and the physical-memory/L2 interface. Successor to the fixed two-client read-only arbiter.

---
 rtl/mem_arbiter_rr_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_picker.sv | 32 +++
 rtl/mem_arbiter_rr.sv | 117 +++++++++++
 tb/tb_mem_arbiter_rr.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the memory-port arbiter: FSM states, transaction op and
// the grant-index width helper.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  // Grant index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotate-and-priority-encode: the first requester found when
// searching upward from i_ptr+1 (mod N_CH) wins.
module rr_picker
  import arbiter_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic            o_valid,
  output logic [CH_W-1:0] o_idx
);

  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  int                w_base;

  assign w_dbl = {i_req, i_req};

  always_comb begin
    w_base  = (int'(i_ptr) + 1) % N_CH;
    w_rot   = w_dbl[w_base +: N_CH];
    o_valid = |w_rot;
    o_idx   = '0;
    // Descending scan so the lowest rotated position is the final assignment.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) o_idx = CH_W'((w_base + k) % N_CH);
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-client arbiter sharing one memory port (IDLE -> BUSY -> RELEASE).
// Define ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module mem_arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int CH_W   = ch_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          cli_read,
  input  logic [N_CH-1:0]          cli_write,
  input  logic [N_CH*ADDR_W-1:0]   cli_addr,
  input  logic [N_CH*DATA_W-1:0]   cli_wdata,
  output logic [DATA_W-1:0]        cli_rdata,
  output logic [N_CH-1:0]          cli_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_resp,
  output logic                     grant_valid,
  output logic [CH_W-1:0]          grant_id
);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  arb_op_e         r_op;
  logic [CH_W-1:0] r_grant_id;
  logic [N_CH-1:0] w_req;
  logic            w_pick_vld;
  logic [CH_W-1:0] w_pick_idx;
  logic [CH_W-1:0] w_ptr;
  logic            w_grant;

  assign w_req   = cli_read | cli_write;
  assign w_grant = (r_state == ST_IDLE) && w_pick_vld;

`ifdef ARB_RR_EN
  logic [CH_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= CH_W'(N_CH - 1);
    else if (w_grant) r_ptr <= w_pick_idx;
  end

  assign w_ptr = r_ptr;
`else
  // Pointer parked at the top index makes the search start at client 0.
  assign w_ptr = CH_W'(N_CH - 1);
`endif

  rr_picker #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_picker (
    .i_req   (w_req),
    .i_ptr   (w_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_grant_id <= w_pick_idx;
    end
  end

  // Write wins when a client raises both strobes.
  always_ff @(posedge clk) begin
    if (w_grant) r_op <= cli_write[w_pick_idx] ? OP_WR : OP_RD;
  end

  always_comb begin
    w_state_nxt = r_state;
    grant_valid = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cli_rdata   = '0;
    cli_resp    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        grant_valid = 1'b1;
        mem_read    = (r_op == OP_RD);
        mem_write   = (r_op == OP_WR);
        mem_addr    = cli_addr[int'(r_grant_id) * ADDR_W +: ADDR_W];
        mem_wdata   = cli_wdata[int'(r_grant_id) * DATA_W +: DATA_W];
        if (mem_resp) begin
          cli_resp[r_grant_id] = 1'b1;
          cli_rdata            = mem_rdata;
          w_state_nxt          = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr (N_CH=4): random clients and memory,
// a transaction-level arbitration model feeding an expected-grant queue.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cli_read, cli_write;
  logic [N*AW-1:0] cli_addr;
  logic [N*DW-1:0] cli_wdata;
  logic [DW-1:0]   cli_rdata;
  logic [N-1:0]    cli_resp;
  logic            mem_read, mem_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_resp;
  logic            grant_valid;
  logic [CW-1:0]   grant_id;

  mem_arbiter_rr #(
    .N_CH   (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cli_read    (cli_read),
    .cli_write   (cli_write),
    .cli_addr    (cli_addr),
    .cli_wdata   (cli_wdata),
    .cli_rdata   (cli_rdata),
    .cli_resp    (cli_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  logic [N-1:0] cl_mask;
  logic [N-1:0] drop_now;
  bit           gap_en;
  bit           force_resp;
  int           lat_min, lat_max;

  // Reference model: whole-transaction view of the arbiter
  typedef enum {M_IDLE, M_BUSY, M_REL} mstate_t;
  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  mstate_t m_st  = M_IDLE;
  int      m_ptr = N - 1;
  txn_t    exp_q[$];
  txn_t    m_t;
  logic [N-1:0] m_req;
  int      m_w;

  // Winner = requester at the smallest circular distance past the pointer.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    int best = -1;
    int bd   = N + 1;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        int d = (i - ptr - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st  = M_IDLE;
      m_ptr = N - 1;
      exp_q.delete();
    end else begin
      case (m_st)
        M_IDLE: begin
          m_req = cli_read | cli_write;
          if (m_req != '0) begin
            m_w = pick(m_req, m_ptr);
`ifdef ARB_RR_EN
            m_ptr = m_w;
`endif
            m_t.id    = m_w;
            m_t.wr    = cli_write[m_w];
            m_t.addr  = cli_addr[m_w*AW +: AW];
            m_t.wdata = cli_wdata[m_w*DW +: DW];
            exp_q.push_back(m_t);
            m_st = M_BUSY;
          end
        end
        M_BUSY:  if (mem_resp) m_st = M_REL;
        default: m_st = M_IDLE;
      endcase
    end
  end

  // Monitor
  bit           popped = 0;
  bit           cur_ok = 0;
  txn_t         cur;
  logic [N-1:0] exp_resp;
  bit           exp_busy;

  always @(negedge clk) begin
    exp_busy = (m_st == M_BUSY);
    chk("grant_valid", grant_valid, exp_busy);
    chk("strobe", mem_read | mem_write, exp_busy);
    if ((mem_read | mem_write) && !popped) begin
      popped = 1;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_grant: got id %0d expected none at %0t", grant_id, $time);
        cur_ok = 0;
      end else begin
        cur    = exp_q.pop_front();
        cur_ok = 1;
        chk("grant_id", grant_id, cur.id);
        chk("mem_write", mem_write, cur.wr);
        chk("mem_read", mem_read, !cur.wr);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
    end
    if (!(mem_read | mem_write)) popped = 0;
    exp_resp = (exp_busy && mem_resp && cur_ok) ? (N'(1) << cur.id) : '0;
    chk("cli_resp", cli_resp, exp_resp);
    if (exp_resp != '0) chk("cli_rdata", cli_rdata, mem_rdata);
  end

  // Memory model: random latency, response held for one cycle
  bit mem_busy = 0;
  int mem_lat  = 0;

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!(mem_read | mem_write)) begin
        mem_busy  = 0;
        mem_resp  = force_resp;
        mem_rdata = {$urandom, $urandom};
      end else begin
        if (!mem_busy) begin
          mem_busy = 1;
          mem_lat  = $urandom_range(lat_max, lat_min);
        end
        if (mem_lat == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = {$urandom, $urandom};
        end else begin
          mem_lat--;
          mem_resp = 1'b0;
        end
      end
    end
  end

  // Client driver: one outstanding request per client, held until response
  bit [N-1:0] waiting = '0;
  bit [N-1:0] done    = '0;

  initial begin
    int op;
    cli_read  = '0;
    cli_write = '0;
    cli_addr  = '0;
    cli_wdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (waiting[i] && (cli_resp[i] || drop_now[i])) done[i] = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          cli_read[i]  = 1'b0;
          cli_write[i] = 1'b0;
          waiting[i]   = 0;
          done[i]      = 0;
        end else if (!waiting[i] && cl_mask[i] && !(gap_en && $urandom_range(2, 0) == 0)) begin
          op = $urandom_range(9, 0);
          cli_addr[i*AW +: AW]  = $urandom;
          cli_wdata[i*DW +: DW] = {$urandom, $urandom};
          cli_write[i] = (op >= 5);
          cli_read[i]  = (op < 5) || (op == 9);
          waiting[i]   = 1;
        end
      end
    end
  end

  task automatic wait_state(input mstate_t s, input string nm);
    for (int k = 0; k < 200 && m_st != s; k++) @(negedge clk);
    checks++;
    if (m_st != s) begin
      errs++;
      $display("FAIL %s: state %0d never reached, still %0d", nm, s, m_st);
    end
  endtask

  task automatic drain();
    cl_mask = '0;
    repeat (80) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    cl_mask    = '1;
    drop_now   = '0;
    gap_en     = 0;
    force_resp = 0;
    lat_min    = 0;
    lat_max    = 3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    gap_en = 1;
    repeat (400) @(posedge clk);

    // Every client requesting, single-cycle memory
    #1;
    gap_en  = 0;
    lat_min = 0;
    lat_max = 0;
    repeat (60) @(posedge clk);
    #1;
    drain();

    // Stray memory response while idle
    force_resp = 1;
    repeat (3) @(posedge clk);
    #1 force_resp = 0;
    repeat (3) @(posedge clk);
    #1;

    // Owner drops its request mid-transaction while another arrives
    lat_min = 4;
    lat_max = 4;
    cl_mask = 4'b0001;
    wait_state(M_BUSY, "busy_client0");
    @(posedge clk);
    #1;
    cl_mask  = 4'b0010;
    drop_now = 4'b0001;
    repeat (30) @(posedge clk);
    #1 drop_now = '0;
    drain();

    // Reset while a transaction is outstanding
    cl_mask = '1;
    wait_state(M_BUSY, "busy_before_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    drain();

    lat_min = 0;
    lat_max = 3;
    gap_en  = 1;
    cl_mask = '1;
    repeat (300) @(posedge clk);
    #1;
    drain();

    chk("queue_drained", exp_q.size(), 0);
    chk("final_idle_valid", grant_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
